// File: rtl/can_timing_pkg.sv
// rtl/can_timing_pkg.sv - shared types and helpers for the CAN bit timing logic
package can_timing_pkg;

  // Segment of the nominal bit currently being timed
  typedef enum logic [1:0] {
    SYNC = 2'd0,
    PROP = 2'd1,
    PH1  = 2'd2,
    PH2  = 2'd3
  } seg_e;

  // PHASE2 must leave room for the information processing time
  localparam int MIN_PH2 = 2;

  // Internal arithmetic width; wide enough for PROP + extended PHASE1
  localparam int CALC_W = 8;

  // SJW can never exceed PHASE1, otherwise a late edge could eat the sample point
  function automatic logic [CALC_W-1:0] eff_sjw(input logic [CALC_W-1:0] sjw_len,
                                                input logic [CALC_W-1:0] ph1_len);
    return (sjw_len < ph1_len) ? sjw_len : ph1_len;
  endfunction

endpackage

// File: rtl/can_edge_detect.sv
// rtl/can_edge_detect.sv - recessive-to-dominant edge strobe sampled at each time quantum
module can_edge_detect (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_enable,
  input  logic i_tq_pulse,
  input  logic i_rx,
  output logic o_edge
);

  logic r_prev_rx;

  // Bus level seen at the previous time quantum; idles recessive
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_prev_rx <= 1'b1;
    end else if (!i_enable) begin
      r_prev_rx <= 1'b1;
    end else if (i_tq_pulse) begin
      r_prev_rx <= i_rx;
    end
  end

  assign o_edge = i_tq_pulse & r_prev_rx & ~i_rx;

endmodule

// File: rtl/can_bit_timing.sv
// rtl/can_bit_timing.sv - CAN nominal bit segmentation with hard sync and SJW-limited resync
module can_bit_timing
  import can_timing_pkg::*;
#(
  parameter int SEG_W = 3,
  parameter int SJW_W = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             tq_pulse,
  input  logic             rx,
  input  logic [SEG_W-1:0] prop_seg,
  input  logic [SEG_W-1:0] phase_seg1,
  input  logic [SEG_W-1:0] phase_seg2,
  input  logic [SJW_W-1:0] sjw,
  input  logic             hard_sync_en,
  input  logic             resync_en,
  output logic             tx_point,
  output logic             sample_point,
  output logic             sampled_bit,
  output logic             hard_synced,
  output logic [1:0]       seg
);

  seg_e              r_seg;
  logic [CALC_W-1:0] r_cnt;
  logic [CALC_W-1:0] r_ph1_ext;
  logic              r_sync_done;
  logic              r_first;
  logic              r_tx;
  logic              r_sp;
  logic              r_hs;
  logic              r_sbit;

  seg_e              w_seg_n;
  logic [CALC_W-1:0] w_cnt_n;
  logic [CALC_W-1:0] w_ext_n;
  logic              w_done_n;
  logic              w_first_n;
  logic              w_tx_n;
  logic              w_sp_n;
  logic              w_hs_n;
  logic              w_sbit_n;

  logic              w_edge;
  logic              w_resync;
  logic              w_early_end;
  logic              w_shorten;
  logic [CALC_W-1:0] w_lp;
  logic [CALC_W-1:0] w_ps2;
  logic [CALC_W-1:0] w_l2;
  logic [CALC_W-1:0] w_sjwe;
  logic [CALC_W-1:0] w_elapsed;
  logic [CALC_W-1:0] w_e;
  logic [CALC_W-1:0] w_rem;
  logic [CALC_W-1:0] w_l1;

  can_edge_detect u_edge (
    .i_clock    (clock),
    .i_reset_n  (reset_n),
    .i_enable   (enable),
    .i_tq_pulse (tq_pulse),
    .i_rx       (rx),
    .o_edge     (w_edge)
  );

  assign w_lp      = CALC_W'(prop_seg) + CALC_W'(1);
  assign w_ps2     = CALC_W'(phase_seg2) + CALC_W'(1);
  assign w_l2      = (w_ps2 < CALC_W'(MIN_PH2)) ? CALC_W'(MIN_PH2) : w_ps2;
  assign w_sjwe    = eff_sjw(CALC_W'(sjw) + CALC_W'(1), CALC_W'(phase_seg1) + CALC_W'(1));
  assign w_elapsed = r_cnt + CALC_W'(1);

  // Per-tq segment sequencing, hard sync and resync correction
  always_comb begin
    w_seg_n     = r_seg;
    w_cnt_n     = r_cnt;
    w_ext_n     = r_ph1_ext;
    w_done_n    = r_sync_done;
    w_first_n   = r_first;
    w_tx_n      = 1'b0;
    w_sp_n      = 1'b0;
    w_hs_n      = 1'b0;
    w_sbit_n    = r_sbit;
    w_resync    = 1'b0;
    w_early_end = 1'b0;
    w_shorten   = 1'b0;
    w_e         = '0;
    w_rem       = '0;
    w_l1        = '0;
    if (tq_pulse) begin
      w_first_n = 1'b0;
      if (w_edge && hard_sync_en) begin
        // The edge tq itself becomes SYNC, so the next tq is the first of PROP
        w_seg_n  = PROP;
        w_cnt_n  = '0;
        w_ext_n  = '0;
        w_done_n = 1'b1;
        w_hs_n   = 1'b1;
      end else begin
        w_resync = w_edge && resync_en && !r_sync_done;
        if (w_resync) begin
          w_done_n = 1'b1;
          case (r_seg)
            PROP: begin
              w_e     = w_elapsed;
              w_ext_n = (w_e < w_sjwe) ? w_e : w_sjwe;
            end
            PH1: begin
              w_e     = w_lp + w_elapsed;
              w_ext_n = (w_e < w_sjwe) ? w_e : w_sjwe;
            end
            PH2: begin
              w_rem = w_l2 - w_elapsed;
              if (w_rem <= w_sjwe) begin
                w_early_end = 1'b1;
              end else begin
                w_shorten = 1'b1;
              end
            end
            default: ;
          endcase
        end
        // PHASE1 length includes any extension granted at this very tq
        w_l1 = CALC_W'(phase_seg1) + CALC_W'(1) + w_ext_n;
        case (r_seg)
          SYNC: begin
            // After reset the first tq is the entry into SYNC, not the SYNC tq itself
            if (r_first) begin
              w_tx_n = 1'b1;
            end else begin
              w_seg_n = PROP;
            end
            w_cnt_n = '0;
          end
          PROP: begin
            if (w_elapsed >= w_lp) begin
              w_seg_n = PH1;
              w_cnt_n = '0;
            end else begin
              w_cnt_n = w_elapsed;
            end
          end
          PH1: begin
            if (w_elapsed >= w_l1) begin
              w_seg_n  = PH2;
              w_cnt_n  = '0;
              w_sp_n   = 1'b1;
              w_sbit_n = rx;
            end else begin
              w_cnt_n = w_elapsed;
            end
          end
          PH2: begin
            if (w_early_end || (w_elapsed >= w_l2)) begin
              w_seg_n  = SYNC;
              w_cnt_n  = '0;
              w_ext_n  = '0;
              w_done_n = 1'b0;
              w_tx_n   = 1'b1;
            end else if (w_shorten) begin
              w_cnt_n = w_elapsed + w_sjwe;
            end else begin
              w_cnt_n = w_elapsed;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Timing state and registered strobes; disable forces the idle state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_seg       <= SYNC;
      r_cnt       <= '0;
      r_ph1_ext   <= '0;
      r_sync_done <= 1'b0;
      r_first     <= 1'b1;
      r_tx        <= 1'b0;
      r_sp        <= 1'b0;
      r_hs        <= 1'b0;
      r_sbit      <= 1'b1;
    end else if (!enable) begin
      r_seg       <= SYNC;
      r_cnt       <= '0;
      r_ph1_ext   <= '0;
      r_sync_done <= 1'b0;
      r_first     <= 1'b1;
      r_tx        <= 1'b0;
      r_sp        <= 1'b0;
      r_hs        <= 1'b0;
      r_sbit      <= 1'b1;
    end else begin
      r_seg       <= w_seg_n;
      r_cnt       <= w_cnt_n;
      r_ph1_ext   <= w_ext_n;
      r_sync_done <= w_done_n;
      r_first     <= w_first_n;
      r_tx        <= w_tx_n;
      r_sp        <= w_sp_n;
      r_hs        <= w_hs_n;
      r_sbit      <= w_sbit_n;
    end
  end

  assign tx_point     = r_tx;
  assign sample_point = r_sp;
  assign hard_synced  = r_hs;
  assign sampled_bit  = r_sbit;
  assign seg          = r_seg;

endmodule

// File: doc/can_bit_timing.md
Name: can_bit_timing

Overview:
CAN bit timing state machine. It consumes the time-quantum pulse from tq_generator and divides each nominal bit into SYNC, PROP, PHASE1 and PHASE2 segments. It emits the transmit point and the sample point, and samples the bus bit. It applies hard synchronisation and resynchronisation (SJW-limited) on recessive-to-dominant edges, and sits between the tq generator and the CAN bit stream processor.

Parameters:
SEG_W, 3, width of the prop_seg, phase_seg1 and phase_seg2 fields (segment length = field+1 tq)
SJW_W, 2, width of the sjw field (SJW = field+1 tq)

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  bit timing enabled; low forces idle
tq_pulse  input  1  one-clock strobe per time quantum, from tq_generator
rx  input  1  bus level, already synchronised to clock (1 = recessive)
prop_seg  input  SEG_W  PROP length-1
phase_seg1  input  SEG_W  PHASE1 length-1
phase_seg2  input  SEG_W  PHASE2 length-1 (effective min 2 tq)
sjw  input  SJW_W  SJW-1
hard_sync_en  input  1  next edge performs a hard sync (bus idle / SOF)
resync_en  input  1  resynchronisation permitted
tx_point  output  1  one-clock pulse at start of SYNC
sample_point  output  1  one-clock pulse at end of PHASE1
sampled_bit  output  1  rx value captured at the last sample point
hard_synced  output  1  one-clock pulse when a hard sync is applied
seg  output  2  current segment (SYNC/PROP/PH1/PH2)

Behaviour:
- Reset and enable=0:
  - seg=SYNC; tq counter=0; sync_done=0; ph1_ext=0.
  - sampled_bit=1 and prev_rx=1.
  - tx_point, sample_point and hard_synced are 0.
- State advances only in cycles with tq_pulse=1. Cycles without tq_pulse hold all state.
- Configuration inputs are read live; software changes them only while enable=0.
- Edge detection: an edge is prev_rx=1 and rx=0, evaluated at tq_pulse. prev_rx updates at every tq_pulse.
- Effective lengths:
  - Lp=prop_seg+1.
  - L1=phase_seg1+1+ph1_ext.
  - L2=max(phase_seg2+1,2).
  - SJWe=min(sjw+1, phase_seg1+1).
- Nominal sequence: SYNC (1 tq) -> PROP (Lp) -> PH1 (L1) -> PH2 (L2) -> SYNC. The counter resets at each segment change.
- tx_point: registered; asserts in the clock after the tq_pulse that enters SYNC.
- sample_point: registered; asserts in the clock after the tq_pulse that ends PH1. sampled_bit=rx, captured at that same tq_pulse.
- Leaving PH2 clears ph1_ext and sync_done.
- Hard sync: takes priority over resync.
  - Trigger: edge with hard_sync_en=1, in any segment.
  - The edge tq is treated as SYNC; next state is PROP with counter 0.
  - ph1_ext=0, sync_done=1.
  - hard_synced pulses in the clock after the edge tq.
  - No tx_point is generated for it.
- Resync: edge with resync_en=1, hard_sync_en=0 and sync_done=0. Sets sync_done=1.
  - Edge in SYNC: e=0, no correction.
  - Edge in PROP/PH1: e = tq elapsed since end of SYNC, including the edge tq. ph1_ext=min(e,SJWe).
  - Edge in PH2: r = L2 - (tq elapsed in PH2, including the edge tq).
    - If r<=SJWe, the next tq is SYNC (bit ends immediately, tx_point follows).
    - Otherwise PH2 is shortened by SJWe.
- Only the first qualifying edge per bit (between PH2 exits) is applied. Later edges only update prev_rx.
- When tq_pulse and a configuration change coincide, the value sampled at that tq is used.
- Deasserting enable mid-bit: immediate return to the reset state on the next clock. No pulses are emitted in that clock.
- Asynchronous reset mid-operation: identical to power-on reset.

Decomposition:
- can_timing_pkg: seg_e enum (SYNC=0, PROP=1, PH1=2, PH2=3), MIN_PH2=2, and a function for effective SJW.
- One sub-module is natural: can_edge_detect (prev_rx register plus edge strobe qualified by tq_pulse).

Test Plan:
- Nominal timing: tq_pulse every 4 clocks, prop=1, ph1=2, ph2=2, rx=1 -> tx_point every 9 tq (36 clocks); sample_point 6 tq after each tx_point; sampled_bit=1.
- Hard sync: hard_sync_en=1, drop rx to 0 during PH1 -> hard_synced pulse; sample_point exactly 5 tq after the edge tq; sampled_bit=0.
- Late edge: resync_en=1, sjw=0, edge at PROP tq 2 (e=2) -> ph1_ext=1, bit lasts 10 tq, sample_point delayed 1 tq.
- Early edge: sjw=1, edge with r=1 in PH2 -> tx_point on the next tq; bit shortened by 1 tq.
- Second edge: two edges in one bit with resync_en=1 -> only the first is corrected. Bit length matches the single-edge case.
- Disable: enable=0 during PH1 -> seg=SYNC and outputs 0 the next clock. Re-enable -> tx_point on the first tq; the sequence restarts.
